// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, grant codes
// and the master-to-slave request payload.
package wshb_arb_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = DAT_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [SEL_W-1:0] sel;
    logic [2:0]       cti;
    logic [1:0]       bte;
    logic [DAT_W-1:0] dat;
  } wshb_req_t;

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone B4 bus bundle, 32-bit address and data.
interface wshb_if;
  logic                            cyc;
  logic                            stb;
  logic                            we;
  logic [wshb_arb_pkg::ADR_W-1:0]  adr;
  logic [wshb_arb_pkg::SEL_W-1:0]  sel;
  logic [2:0]                      cti;
  logic [1:0]                      bte;
  logic [wshb_arb_pkg::DAT_W-1:0]  dat_ms;
  logic [wshb_arb_pkg::DAT_W-1:0]  dat_sm;
  logic                            ack;
  logic                            err;
  logic                            rty;

  modport master (output cyc, stb, we, adr, sel, cti, bte, dat_ms,
                  input  dat_sm, ack, err, rty);
  modport slave  (input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
                  output dat_sm, ack, err, rty);
endinterface

// File: rtl/wshb_arb_core.sv
// Grant decision FSM with per-grant ack quota.
// WSHB_ARB_ROUND_ROBIN_EN: resolve IDLE ties against the last-granted master.
module wshb_arb_core
  import wshb_arb_pkg::*;
#(
  parameter int unsigned QUOTA = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       cyc0_i,
  input  logic       cyc1_i,
  input  logic       ack_i,
  output logic [1:0] grant_o,
  output arb_state_e state_o
);

  localparam int unsigned CNT_W = $clog2(QUOTA) + 1;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             quota_hit;
  logic             tie_to_m1;

`ifdef WSHB_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign tie_to_m1 = ~last_q;
`else
  assign tie_to_m1 = 1'b0;
`endif

  assign quota_hit = ack_i && (cnt_q == CNT_W'(QUOTA - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef WSHB_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef WSHB_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next state: release on cyc drop or on quota exhaustion with contention
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req0_i && req1_i) state_d = tie_to_m1 ? GNT1 : GNT0;
        else if (req0_i)      state_d = GNT0;
        else if (req1_i)      state_d = GNT1;
      end
      GNT0: if (!cyc0_i || (quota_hit && req1_i)) state_d = req1_i ? GNT1 : IDLE;
      GNT1: if (!cyc1_i || (quota_hit && req0_i)) state_d = req0_i ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q)                 cnt_d = '0;
    else if (ack_i && (state_q != IDLE))    cnt_d = cnt_q + CNT_W'(1);
  end

`ifdef WSHB_ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
    if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
  end
`endif

  // Outputs decoded straight from the state register
  always_comb begin
    grant_o = GRANT_NONE;
    case (state_q)
      GNT0:    grant_o = GRANT_M0;
      GNT1:    grant_o = GRANT_M1;
      default: grant_o = GRANT_NONE;
    endcase
    state_o = state_q;
  end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter onto one SDRAM port; bus mux lives here.
// WSHB_ARB_ROUND_ROBIN_EN selects round-robin tie breaking in the core.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int unsigned QUOTA = 16
) (
  input  logic       clk,
  input  logic       rst,
  wshb_if.slave      wshb_ifs0,
  wshb_if.slave      wshb_ifs1,
  wshb_if.master     wshb_ifm,
  output logic [1:0] grant
);

  arb_state_e state;
  wshb_req_t  m0_req, m1_req, sel_req;
  logic       req0, req1;

  assign req0 = wshb_ifs0.cyc & wshb_ifs0.stb;
  assign req1 = wshb_ifs1.cyc & wshb_ifs1.stb;

  wshb_arb_core #(.QUOTA(QUOTA)) u_core (
    .clk     (clk),
    .rst     (rst),
    .req0_i  (req0),
    .req1_i  (req1),
    .cyc0_i  (wshb_ifs0.cyc),
    .cyc1_i  (wshb_ifs1.cyc),
    .ack_i   (wshb_ifm.ack),
    .grant_o (grant),
    .state_o (state)
  );

  always_comb begin
    m0_req = {wshb_ifs0.cyc, wshb_ifs0.stb, wshb_ifs0.we, wshb_ifs0.adr,
              wshb_ifs0.sel, wshb_ifs0.cti, wshb_ifs0.bte, wshb_ifs0.dat_ms};
    m1_req = {wshb_ifs1.cyc, wshb_ifs1.stb, wshb_ifs1.we, wshb_ifs1.adr,
              wshb_ifs1.sel, wshb_ifs1.cti, wshb_ifs1.bte, wshb_ifs1.dat_ms};
  end

  // Owner's request goes to the slave; nothing is driven while idle
  always_comb begin
    sel_req = '0;
    case (state)
      GNT0:    sel_req = m0_req;
      GNT1:    sel_req = m1_req;
      default: sel_req = '0;
    endcase
  end

  assign wshb_ifm.cyc    = sel_req.cyc;
  assign wshb_ifm.stb    = sel_req.stb;
  assign wshb_ifm.we     = sel_req.we;
  assign wshb_ifm.adr    = sel_req.adr;
  assign wshb_ifm.sel    = sel_req.sel;
  assign wshb_ifm.cti    = sel_req.cti;
  assign wshb_ifm.bte    = sel_req.bte;
  assign wshb_ifm.dat_ms = sel_req.dat;

  assign wshb_ifs0.ack    = (state == GNT0) & wshb_ifm.ack;
  assign wshb_ifs0.err    = (state == GNT0) & wshb_ifm.err;
  assign wshb_ifs0.rty    = (state == GNT0) & wshb_ifm.rty;
  assign wshb_ifs1.ack    = (state == GNT1) & wshb_ifm.ack;
  assign wshb_ifs1.err    = (state == GNT1) & wshb_ifm.err;
  assign wshb_ifs1.rty    = (state == GNT1) & wshb_ifm.rty;
  assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
  assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 Parameter QUOTA, default 16: acks a master may receive per grant before forced re-arbitration when the other master is requesting.
REQ-002 clk  input  1  Wishbone clock; the only clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wshb_ifs0  wshb_if.slave  32-bit data, 32-bit adr  requester 0 (framebuffer reader, high priority).
REQ-005 wshb_ifs1  wshb_if.slave  32-bit data, 32-bit adr  requester 1 (image writer).
REQ-006 wshb_ifm  wshb_if.master  32-bit data, 32-bit adr  shared SDRAM port.
REQ-007 grant  output  2  one-hot current owner (01 = master 0, 10 = master 1, 00 = idle).

Function
REQ-008 req_i SHALL be cyc_i & stb_i.
REQ-009 FSM states SHALL be IDLE, GNT0 and GNT1, with a registered state.
REQ-010 IDLE: if req0 -> GNT0, else if req1 -> GNT1, else stay in IDLE; with both requesting, see REQ-019.
REQ-011 Request at cycle N from IDLE SHALL give grant and slave-side cyc/stb at N+1; no further latency.
REQ-012 In GNTx, cyc, stb, we, adr, sel, cti, bte and dat_ms to wshb_ifm SHALL be combinationally muxed from master x.
REQ-013 In GNTx, ack, err and rty from wshb_ifm SHALL be routed only to master x; the other master SHALL see 0.
REQ-014 In IDLE, wshb_ifm cyc and stb SHALL be 0.
REQ-015 dat_sm SHALL be broadcast to both masters.
REQ-016 Ack counter (width $clog2(QUOTA)+1) SHALL increment on each routed ack and clear on every grant change.
REQ-017 Release from GNTx SHALL occur when cyc_x = 0 (immediately, even without a pending ack), or when an ack occurs with count == QUOTA-1 and the other master is requesting.
REQ-018 On release, the FSM SHALL go directly to the other GNT state if that master is requesting (no idle bubble), else to IDLE.
REQ-019 Simultaneous req0 and req1 in IDLE: master 0 wins (fixed priority; see REQ-024).
REQ-020 A preempted master keeps stb asserted and is simply not acked until re-granted; its request is not lost and its address is unchanged.
REQ-021 With only one master requesting, the grant SHALL be held indefinitely (the quota does not apply).

Reset
REQ-022 While rst = 1: state = IDLE, count = 0, grant = 00, wshb_ifm cyc/stb = 0, all acks to masters = 0; the round-robin pointer = master 1 (so master 0 wins first).
REQ-023 rst asserted mid-transaction SHALL drop cyc/stb in the same cycle (asynchronous); an ack arriving during reset SHALL be discarded.

Configuration
REQ-024 Macro WSHB_ARB_ROUND_ROBIN_EN:
- Defined: IDLE ties are resolved against the last-granted master via a registered pointer, updated on every grant.
- Undefined: fixed priority master 0, and no pointer register exists.

Structure
REQ-025 Package wshb_arb_pkg SHALL hold the state enum (IDLE, GNT0, GNT1) and grant encoding constants.
REQ-026 The decision logic SHALL be one sub-module, wshb_arb_core (req0, req1, cyc0, cyc1, ack -> grant, state). The signal mux SHALL stay in the top level.

Verification
REQ-027 Bench SHALL cover the following directed scenarios:
- Reset release, req1 alone at cycle 3 -> grant = 10 at cycle 4; wshb_ifm.adr equals master 1 adr.
- req0 and req1 both in IDLE, macro undefined -> grant = 01; macro defined after a prior GNT0 -> grant = 10.
- QUOTA = 4, both requesting continuously, slave acks every cycle -> grant alternates every 4 acks; ifs1 ack = 0 while grant = 01.
- Master 1 alone, 100 acks -> grant stays 10 throughout; no preemption.
- GNT1, cyc1 drops with no ack while req0 = 1 -> grant = 01 next cycle; count = 0.
- rst pulse during GNT0 with stb pending -> wshb_ifm.stb = 0 in that cycle; grant = 00; late ack ignored; master 0 is re-granted one cycle after rst falls.
